// File: rtl/pgnoc_pkg.sv
// pgnoc_pkg: types and constants shared by the packet-NoC router blocks.
package pgnoc_pkg;

    // Width of a routed output-port code on the req_port bus.
    localparam int PORT_W = 4;

    // Per-output-port arbitration state.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Saturate a raw port code so anything past the last port lands on it.
    function automatic logic [PORT_W-1:0] clamp_port(
        input logic [PORT_W-1:0] raw,
        input logic [PORT_W-1:0] last_port
    );
        return (raw > last_port) ? last_port : raw;
    endfunction

endpackage

// File: rtl/port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search. Returns the first set request
// at or above the pointer, wrapping to the lowest set request otherwise.
module rr_picker #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_winner,
    output logic             o_valid
);

    logic [N-1:0] w_hi_mask;
    logic [N-1:0] w_hi_req;
    logic [N-1:0] w_sel;

    // Mask off requests below the pointer, fall back to the full set, isolate lowest bit.
    always_comb begin
        w_hi_mask = {N{1'b1}} << i_ptr;
        w_hi_req  = i_req & w_hi_mask;
        w_sel     = (|w_hi_req) ? w_hi_req : i_req;
        o_winner  = w_sel & (~w_sel + N'(1));
        o_valid   = |i_req;
    end

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: one IDLE/LOCKED arbiter per output port (neighbours plus the
// local port PORTS_NUM). A lock holds a requester on a port until its tail
// flit transfers, keeping packets atomic. Define ARB_TIMEOUT_EN to add a
// per-port watchdog that force-releases a lock after TIMEOUT cycles without
// an owner transfer.
module port_arbiter
    import pgnoc_pkg::*;
#(
    parameter int PORTS_NUM = 4,
    parameter int REQ_NUM   = PORTS_NUM + 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      a_rst,
    input  logic [REQ_NUM-1:0]        req,
    input  logic [PORT_W*REQ_NUM-1:0] req_port,
    input  logic [REQ_NUM-1:0]        xfer,
    input  logic [REQ_NUM-1:0]        tail,
    output logic [REQ_NUM-1:0]        grant,
    output logic [PORTS_NUM:0]        busy
);

    localparam int               OUT_NUM  = PORTS_NUM + 1;
    localparam int               IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(REQ_NUM - 1);

    if (OUT_NUM > (1 << PORT_W)) begin : g_bad_ports
        $error("port_arbiter: PORTS_NUM does not fit the req_port field");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("port_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t         r_state     [OUT_NUM];
    logic [IDX_W-1:0]   r_owner     [OUT_NUM];
    logic [IDX_W-1:0]   r_rr_ptr    [OUT_NUM];

    arb_state_t         w_state_nxt [OUT_NUM];
    logic [IDX_W-1:0]   w_owner_nxt [OUT_NUM];
    logic [IDX_W-1:0]   w_ptr_nxt   [OUT_NUM];

    logic [PORT_W-1:0]  w_tgt       [REQ_NUM];
    logic [REQ_NUM-1:0] w_cand      [OUT_NUM];
    logic [REQ_NUM-1:0] w_pick_oh   [OUT_NUM];
    logic [REQ_NUM-1:0] w_owner_oh  [OUT_NUM];
    logic [IDX_W-1:0]   w_win_idx   [OUT_NUM];
    logic [OUT_NUM-1:0] w_pick_vld;
    logic [OUT_NUM-1:0] w_win_vld;
    logic [OUT_NUM-1:0] w_release;
    logic [REQ_NUM-1:0] w_claimed;

`ifdef ARB_TIMEOUT_EN
    localparam int      WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]    r_wdog      [OUT_NUM];
    logic [OUT_NUM-1:0] w_own_xfer;
`endif

    // Decode each requester's target, steering misrouted codes to the local port.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            w_tgt[i] = clamp_port(req_port[PORT_W*i +: PORT_W], PORT_W'(PORTS_NUM));
        end
    end

    // Build per-port candidate sets; an already-granted requester competes nowhere.
    always_comb begin
        for (int p = 0; p < OUT_NUM; p++) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                w_cand[p][i] = req[i] && !grant[i] && (w_tgt[i] == PORT_W'(p));
            end
        end
    end

    for (genvar p = 0; p < OUT_NUM; p++) begin : g_port
        rr_picker #(
            .N     (REQ_NUM),
            .IDX_W (IDX_W)
        ) u_rr_picker (
            .i_req    (w_cand[p]),
            .i_ptr    (r_rr_ptr[p]),
            .o_winner (w_pick_oh[p]),
            .o_valid  (w_pick_vld[p])
        );
    end

    // Resolve same-requester collisions in favour of the lower port; encode winners.
    always_comb begin
        // NOTE: every combinational output is given a default before any
        // conditional update, so no path leaves it unassigned (no latch).
        w_claimed = '0;
        for (int p = 0; p < OUT_NUM; p++) begin
            w_win_vld[p] = (r_state[p] == IDLE) && w_pick_vld[p] &&
                           ((w_pick_oh[p] & w_claimed) == '0);
            if (w_win_vld[p]) begin
                w_claimed = w_claimed | w_pick_oh[p];
            end
            w_win_idx[p] = '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (w_pick_oh[p][i]) begin
                    w_win_idx[p] = IDX_W'(i);
                end
            end
        end
    end

    // Owner decode and release conditions; only the owner's xfer/tail count.
    always_comb begin
        for (int p = 0; p < OUT_NUM; p++) begin
            w_owner_oh[p] = REQ_NUM'(1) << r_owner[p];
            w_release[p]  = |(xfer & tail & w_owner_oh[p]);
`ifdef ARB_TIMEOUT_EN
            w_own_xfer[p] = |(xfer & w_owner_oh[p]);
            if (!w_own_xfer[p] && (r_wdog[p] == WD_W'(TIMEOUT - 1))) begin
                w_release[p] = 1'b1;
            end
`endif
        end
    end

    // Next-state logic: IDLE locks onto a winner, LOCKED waits for release.
    always_comb begin
        for (int p = 0; p < OUT_NUM; p++) begin
            w_state_nxt[p] = r_state[p];
            w_owner_nxt[p] = r_owner[p];
            w_ptr_nxt[p]   = r_rr_ptr[p];
            case (r_state[p])
                IDLE: begin
                    if (w_win_vld[p]) begin
                        w_state_nxt[p] = LOCKED;
                        w_owner_nxt[p] = w_win_idx[p];
                    end
                end
                LOCKED: begin
                    if (w_release[p]) begin
                        w_state_nxt[p] = IDLE;
                        w_ptr_nxt[p]   = (r_owner[p] == LAST_REQ) ? '0
                                                                  : r_owner[p] + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    // State register: FSM state, owner and round-robin pointer per port.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int p = 0; p < OUT_NUM; p++) begin
                r_state[p]  <= IDLE;
                r_owner[p]  <= '0;
                r_rr_ptr[p] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every port samples the same
            // pre-edge values and all update together at the clock edge.
            for (int p = 0; p < OUT_NUM; p++) begin
                r_state[p]  <= w_state_nxt[p];
                r_owner[p]  <= w_owner_nxt[p];
                r_rr_ptr[p] <= w_ptr_nxt[p];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog: counts LOCKED cycles since the owner last moved a flit.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int p = 0; p < OUT_NUM; p++) begin
                r_wdog[p] <= '0;
            end
        end else begin
            for (int p = 0; p < OUT_NUM; p++) begin
                if ((r_state[p] != LOCKED) || w_own_xfer[p] || w_release[p]) begin
                    r_wdog[p] <= '0;
                end else begin
                    r_wdog[p] <= r_wdog[p] + WD_W'(1);
                end
            end
        end
    end
`endif

    // Outputs: busy per locked port, grant for each locked port's owner.
    always_comb begin
        grant = '0;
        busy  = '0;
        for (int p = 0; p < OUT_NUM; p++) begin
            if (r_state[p] == LOCKED) begin
                busy[p] = 1'b1;
                grant   = grant | w_owner_oh[p];
            end
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: directed scoreboard bench. Stimulus pushes the expected
// grant/busy for a given cycle; the monitor samples on the falling edge and
// compares. Expectations follow the ARB_TIMEOUT_EN setting of the build.
module tb_port_arbiter;

    localparam int PORTS_NUM = 4;
    localparam int REQ_NUM   = 5;
    localparam int TIMEOUT   = 8;
    localparam int RR_ORDER [4] = '{0, 1, 3, 0};

    logic        clk = 1'b0;
    logic        a_rst;
    logic [4:0]  req;
    logic [19:0] req_port;
    logic [4:0]  xfer;
    logic [4:0]  tail;
    logic [4:0]  grant;
    logic [4:0]  busy;

    typedef struct {
        string      name;
        int         due;
        logic [4:0] g;
        logic [4:0] b;
    } exp_t;

    exp_t sb [$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   drain_cnt = 0;
    bit   stim_done = 1'b0;

    port_arbiter #(
        .PORTS_NUM (PORTS_NUM),
        .REQ_NUM   (REQ_NUM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .req      (req),
        .req_port (req_port),
        .xfer     (xfer),
        .tail     (tail),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [4:0] got_g, input logic [4:0] got_b,
                         input logic [4:0] exp_g, input logic [4:0] exp_b);
        checks++;
        if (got_g !== exp_g || got_b !== exp_b) begin
            errors++;
            $display("FAIL %s: grant=%b busy=%b, required grant=%b busy=%b",
                     name, got_g, got_b, exp_g, exp_b);
        end
    endtask

    // Monitor: compare every expectation due this cycle, then report once drained.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.due);
            end else begin
                check(e.name, grant, busy, e.g, e.b);
            end
        end
        if (stim_done) begin
            drain_cnt++;
            if (sb.size() == 0 || drain_cnt > 200) begin
                if (sb.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain: %0d expectations left, required 0", sb.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string name, input int due, input logic [4:0] g,
                             input logic [4:0] b);
        exp_t e;
        e.name = name;
        e.due  = due;
        e.g    = g;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [3:0] port);
        req[i]             = 1'b1;
        req_port[4*i +: 4] = port;
    endtask

    task automatic send(input int i, input logic is_tail);
        xfer[i] = 1'b1;
        tail[i] = is_tail;
    endtask

    task automatic clear_xfer();
        xfer = '0;
        tail = '0;
    endtask

    initial begin
        a_rst    = 1'b1;
        req      = '0;
        req_port = '0;
        xfer     = '0;
        tail     = '0;
        tick(2);
        expect_at("reset", cyc, 5'b00000, 5'b00000);

        // Single request: lock appears one edge later.
        a_rst = 1'b0;
        set_req(0, 4'd2);
        expect_at("t1_latency", cyc, 5'b00000, 5'b00000);
        expect_at("t1_grant", cyc + 1, 5'b00001, 5'b00100);
        tick(1);
        req[0] = 1'b0;
        send(0, 1'b1);
        expect_at("t1_release", cyc + 1, 5'b00000, 5'b00000);
        tick(1);
        clear_xfer();

        // Round robin on port 1 among requesters 0, 1, 3, one IDLE cycle between grants.
        set_req(0, 4'd1);
        set_req(1, 4'd1);
        set_req(3, 4'd1);
        for (int k = 0; k < 4; k++) begin
            expect_at($sformatf("t2_grant%0d", k), cyc + 1, 5'(1) << RR_ORDER[k], 5'b00010);
            expect_at($sformatf("t2_idle%0d", k), cyc + 2, 5'b00000, 5'b00000);
            tick(1);
            send(RR_ORDER[k], 1'b1);
            if (k == 3) req = '0;
            tick(1);
            clear_xfer();
        end

        // Owner drops req mid-packet; body flits and a non-owner tail keep the lock.
        set_req(2, 4'd3);
        expect_at("t3_lock", cyc + 1, 5'b00100, 5'b01000);
        tick(1);
        req[2] = 1'b0;
        expect_at("t3_drop", cyc + 1, 5'b00100, 5'b01000);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            send(2, 1'b0);
            send(0, 1'b1);
            expect_at($sformatf("t3_body%0d", k), cyc + 1, 5'b00100, 5'b01000);
        end
        tick(1);
        clear_xfer();
        send(2, 1'b1);
        expect_at("t3_tail", cyc + 1, 5'b00000, 5'b00000);
        tick(1);
        clear_xfer();

        // Out-of-range port codes go to the local port; pointer wraps 4 -> 0.
        set_req(4, 4'd9);
        expect_at("t4_port9", cyc + 1, 5'b10000, 5'b10000);
        tick(1);
        req[4] = 1'b0;
        send(4, 1'b1);
        expect_at("t4_release", cyc + 1, 5'b00000, 5'b00000);
        tick(1);
        clear_xfer();
        set_req(0, 4'd5);
        expect_at("t4_port5", cyc + 1, 5'b00001, 5'b10000);
        tick(1);
        req[0] = 1'b0;
        send(0, 1'b1);
        expect_at("t4_release2", cyc + 1, 5'b00000, 5'b00000);
        tick(1);
        clear_xfer();

        // Two ports lock together; a granted requester retargeting stays masked.
        set_req(0, 4'd0);
        set_req(3, 4'd2);
        expect_at("t5_two_locks", cyc + 1, 5'b01001, 5'b00101);
        tick(1);
        set_req(0, 4'd4);
        expect_at("t5_mask", cyc + 1, 5'b01001, 5'b00101);
        tick(2);

        // Asynchronous reset mid-packet, then lowest requester wins after release.
        set_req(0, 4'd2);
        #1 a_rst = 1'b1;
        expect_at("t5_async_rst", cyc, 5'b00000, 5'b00000);
        tick(2);
        expect_at("t5_rst_hold", cyc, 5'b00000, 5'b00000);
        tick(1);
        a_rst = 1'b0;
        expect_at("t5_pre_arb", cyc, 5'b00000, 5'b00000);
        expect_at("t5_post_rst", cyc + 1, 5'b00001, 5'b00100);
        tick(1);
        req = '0;
        send(0, 1'b1);
        expect_at("t5_release", cyc + 1, 5'b00000, 5'b00000);
        tick(1);
        clear_xfer();

        // Lock with no transfers: watchdog release, or a lock that never times out.
        set_req(1, 4'd0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT; k++) begin
            expect_at($sformatf("t6_held%0d", k), cyc + k, 5'b00010, 5'b00001);
        end
        expect_at("t6_timeout", cyc + TIMEOUT + 1, 5'b00000, 5'b00000);
        tick(1);
        req[1] = 1'b0;
        tick(TIMEOUT + 1);
`else
        expect_at("t6_held1", cyc + 1, 5'b00010, 5'b00001);
        expect_at("t6_held9", cyc + 9, 5'b00010, 5'b00001);
        expect_at("t6_held50", cyc + 50, 5'b00010, 5'b00001);
        expect_at("t6_held100", cyc + 100, 5'b00010, 5'b00001);
        tick(1);
        req[1] = 1'b0;
        tick(99);
        send(1, 1'b1);
        expect_at("t6_tail", cyc + 1, 5'b00000, 5'b00000);
        tick(1);
        clear_xfer();
`endif

        stim_done = 1'b1;
        repeat (1000) @(posedge clk);
        $display("FAIL watchdog: monitor never reported, required a summary");
        $fatal(1, "bench did not terminate");
    end

endmodule
